sd_spi_resp_model: RTL and testbench



---
 rtl/sd_spi_resp_model.sv | 185 ++++++++++++++++++
 tb/tb_sd_spi_resp_model.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_resp_model.sv
// Card-side SD SPI-mode command responder: receives 48-bit frames on SD_IN, checks CRC7/end bit,
// and answers CMD0/CMD8/CMD55/ACMD41/CMD58 with R1/R3/R7 after an NCR gap.
module sd_spi_resp_model #(
  parameter int          NCR             = 2,
  parameter int          ACMD41_BUSY_CNT = 2,
  parameter logic [31:0] OCR             = 32'hC0FF_8000,
  parameter bit          CRC_CHECK       = 1'b1
) (
  input  logic       SD_CLK,
  input  logic       rst,
  input  logic       SD_IN,
  output logic       SD_OUT,
  output logic       cmd_valid,
  output logic [5:0] cmd_index,
  output logic       crc_err,
  output logic       in_idle,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {IDLE, RX, DECODE, WAIT_NCR, TX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  idx_q, idx_d;
  logic [11:0] arg_lo_q, arg_lo_d;
  logic [6:0]  crc_rx_q, crc_rx_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [5:0]  tx_cnt_q, tx_cnt_d;
  logic [39:0] resp_q, resp_d;
  logic        sd_out_q, sd_out_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic        crc_err_q, crc_err_d;
  logic        in_idle_q, in_idle_d;
  logic        app_q, app_d;
  logic [7:0]  acmd_cnt_q, acmd_cnt_d;
  logic [7:0]  r1;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // cmd_valid: single-cycle strobe, no backpressure; cmd_index/crc_err are stable while it is high
  // and hold until the next decoded frame.
  always_comb begin
    state_d     = state_q;
    rx_cnt_d    = rx_cnt_q;
    crc_d       = crc_q;
    idx_d       = idx_q;
    arg_lo_d    = arg_lo_q;
    crc_rx_d    = crc_rx_q;
    wait_cnt_d  = wait_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    resp_d      = resp_q;
    sd_out_d    = 1'b1;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    crc_err_d   = crc_err_q;
    in_idle_d   = in_idle_q;
    app_d       = app_q;
    acmd_cnt_d  = acmd_cnt_q;
    r1          = {7'b0, in_idle_q};

    case (state_q)
      IDLE: begin
        if (!SD_IN) begin
          state_d  = RX;
          rx_cnt_d = 6'd1;
          crc_d    = crc7_step(7'h00, SD_IN);
        end
      end
      RX: begin
        // rx_cnt_q is the MSB-first position of the bit currently on SD_IN
        rx_cnt_d = rx_cnt_q + 6'd1;
        if (rx_cnt_q < 6'd40) crc_d = crc7_step(crc_q, SD_IN);
        if (rx_cnt_q >= 6'd2 && rx_cnt_q <= 6'd7) idx_d = {idx_q[4:0], SD_IN};
        if (rx_cnt_q >= 6'd8 && rx_cnt_q <= 6'd39) arg_lo_d = {arg_lo_q[10:0], SD_IN};
        if (rx_cnt_q >= 6'd40 && rx_cnt_q <= 6'd46) crc_rx_d = {crc_rx_q[5:0], SD_IN};
        if (rx_cnt_q == 6'd1 && !SD_IN) begin
          state_d = IDLE;
        end else if (rx_cnt_q == 6'd47) begin
          state_d     = DECODE;
          cmd_valid_d = 1'b1;
          cmd_index_d = idx_q;
          crc_err_d   = (CRC_CHECK && (crc_q != crc_rx_q)) || !SD_IN;
        end
      end
      DECODE: begin
        state_d    = WAIT_NCR;
        wait_cnt_d = 4'(NCR);
        tx_cnt_d   = 6'd7;
        resp_d     = {r1, 32'h0};
        if (crc_err_q) begin
          resp_d = {8'h08 | r1, 32'h0};
          app_d  = 1'b0;
        end else if (cmd_index_q == 6'd0) begin
          resp_d     = {8'h01, 32'h0};
          in_idle_d  = 1'b1;
          acmd_cnt_d = 8'd0;
          app_d      = 1'b0;
        end else if (cmd_index_q == 6'd8) begin
          resp_d   = {r1, 20'h0, arg_lo_q};
          tx_cnt_d = 6'd39;
        end else if (cmd_index_q == 6'd55) begin
          app_d = 1'b1;
        end else if (cmd_index_q == 6'd41 && app_q) begin
          app_d = 1'b0;
          if (acmd_cnt_q < 8'(ACMD41_BUSY_CNT)) begin
            acmd_cnt_d = acmd_cnt_q + 8'd1;
            resp_d     = {8'h01, 32'h0};
          end else begin
            in_idle_d = 1'b0;
            resp_d    = {8'h00, 32'h0};
          end
        end else if (cmd_index_q == 6'd58) begin
          resp_d   = {r1, ~in_idle_q, OCR[30:0]};
          tx_cnt_d = 6'd39;
        end else begin
          resp_d = {8'h04 | r1, 32'h0};
          app_d  = 1'b0;
        end
      end
      WAIT_NCR: begin
        if (wait_cnt_q <= 4'd1) state_d = TX;
        else wait_cnt_d = wait_cnt_q - 4'd1;
      end
      TX: begin
        sd_out_d = resp_q[39];
        resp_d   = {resp_q[38:0], 1'b0};
        if (tx_cnt_q == 6'd0) state_d = IDLE;
        else tx_cnt_d = tx_cnt_q - 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SD_CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_cnt_q    <= 6'd0;
      crc_q       <= 7'h00;
      idx_q       <= 6'd0;
      arg_lo_q    <= 12'h000;
      crc_rx_q    <= 7'h00;
      wait_cnt_q  <= 4'd0;
      tx_cnt_q    <= 6'd0;
      resp_q      <= 40'h0;
      sd_out_q    <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
      crc_err_q   <= 1'b0;
      in_idle_q   <= 1'b1;
      app_q       <= 1'b0;
      acmd_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      rx_cnt_q    <= rx_cnt_d;
      crc_q       <= crc_d;
      idx_q       <= idx_d;
      arg_lo_q    <= arg_lo_d;
      crc_rx_q    <= crc_rx_d;
      wait_cnt_q  <= wait_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      resp_q      <= resp_d;
      sd_out_q    <= sd_out_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      crc_err_q   <= crc_err_d;
      in_idle_q   <= in_idle_d;
      app_q       <= app_d;
      acmd_cnt_q  <= acmd_cnt_d;
    end
  end

  assign SD_OUT      = sd_out_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_index   = cmd_index_q;
  assign crc_err     = crc_err_q;
  assign in_idle     = in_idle_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_spi_resp_model.sv
// Bench for sd_spi_resp_model: directed card-init sequence plus random command stream,
// responses scored against a byte-level card model.
module tb_sd_spi_resp_model;
  localparam int          NCR_P   = 2;
  localparam int          BUSY_P  = 2;
  localparam logic [31:0] OCR_P   = 32'hC0FF_8000;
  localparam bit          CRC_CHK = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       sd_in;
  logic       sd_out;
  logic       cmd_valid;
  logic [5:0] cmd_index;
  logic       crc_err;
  logic       in_idle;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       m_idle;
  logic       m_app;
  int         m_cnt;

  sd_spi_resp_model #(
    .NCR(NCR_P), .ACMD41_BUSY_CNT(BUSY_P), .OCR(OCR_P), .CRC_CHECK(CRC_CHK)
  ) dut (
    .SD_CLK(clk), .rst(rst), .SD_IN(sd_in), .SD_OUT(sd_out), .cmd_valid(cmd_valid),
    .cmd_index(cmd_index), .crc_err(crc_err), .in_idle(in_idle), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC7 by long division of the message (with 7 zero bits appended) by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg,
                                             input logic bad_crc, input logic bad_end);
    logic [6:0] c;
    c = crc7_ref({2'b01, idx, arg});
    if (bad_crc) c = c ^ 7'h10;
    return {2'b01, idx, arg, c, ~bad_end};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    m_app  = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // Card behaviour: push expected response bytes, return expected crc_err and response length.
  task automatic model_cmd(input logic [47:0] f, output logic e_err, output int nbytes);
    logic [5:0]  idx;
    logic [31:0] ocr;
    idx   = f[45:40];
    e_err = (CRC_CHK && (crc7_ref(f[47:8]) != f[7:1])) || (f[0] == 1'b0);
    nbytes = 1;
    if (e_err) begin
      exp_q.push_back(8'h08 | {7'b0, m_idle});
      m_app = 1'b0;
    end else if (idx == 6'd0) begin
      m_idle = 1'b1; m_cnt = 0; m_app = 1'b0;
      exp_q.push_back(8'h01);
    end else if (idx == 6'd8) begin
      exp_q.push_back({7'b0, m_idle});
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back({4'h0, f[19:16]});
      exp_q.push_back(f[15:8]);
      nbytes = 5;
    end else if (idx == 6'd55) begin
      m_app = 1'b1;
      exp_q.push_back({7'b0, m_idle});
    end else if (idx == 6'd41 && m_app) begin
      m_app = 1'b0;
      if (m_cnt < BUSY_P) begin
        m_cnt++;
        exp_q.push_back(8'h01);
      end else begin
        m_idle = 1'b0;
        exp_q.push_back(8'h00);
      end
    end else if (idx == 6'd58) begin
      ocr     = OCR_P;
      ocr[31] = ~m_idle;
      exp_q.push_back({7'b0, m_idle});
      exp_q.push_back(ocr[31:24]);
      exp_q.push_back(ocr[23:16]);
      exp_q.push_back(ocr[15:8]);
      exp_q.push_back(ocr[7:0]);
      nbytes = 5;
    end else begin
      exp_q.push_back(8'h04 | {7'b0, m_idle});
      m_app = 1'b0;
    end
  endtask

  task automatic drive_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      sd_in = f[i];
      @(posedge clk); #1;
      if (i == 40) begin
        check_eq("line_high_rx", sd_out, 1'b1);
        check_eq("no_valid_rx", cmd_valid, 1'b0);
      end
    end
    sd_in = 1'b1;
  endtask

  task automatic run_cmd(input logic [47:0] f);
    logic       e_err;
    int         nbytes;
    logic [7:0] got;
    logic [7:0] exp;
    model_cmd(f, e_err, nbytes);
    drive_frame(f);
    check_eq("cmd_valid", cmd_valid, 1'b1);
    check_eq("cmd_index", cmd_index, f[45:40]);
    check_eq("crc_err", crc_err, e_err);
    for (int k = 0; k <= NCR_P; k++) begin
      @(posedge clk); #1;
      if (k == 0) check_eq("valid_pulse", cmd_valid, 1'b0);
      check_eq("ncr_gap", sd_out, 1'b1);
    end
    for (int b = 0; b < nbytes; b++) begin
      for (int j = 7; j >= 0; j--) begin
        @(posedge clk); #1;
        got[j] = sd_out;
      end
      exp = exp_q.pop_front();
      check_eq("resp_byte", got, exp);
    end
    check_eq("in_idle", in_idle, m_idle);
    check_eq("cmd_index_hold", cmd_index, f[45:40]);
  endtask

  task automatic init_seq();
    for (int p = 0; p < 3; p++) begin
      run_cmd(make_frame(6'd55, 32'h0, 1'b0, 1'b0));
      run_cmd(make_frame(6'd41, 32'h4000_0000, 1'b0, 1'b0));
    end
  endtask

  initial begin
    logic [5:0]  pick [9];
    logic [47:0] f;
    logic        e_err;
    int          nbytes;
    logic        saw_valid;
    logic        saw_low;
    pick = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd58, 6'd13, 6'd55, 6'd41, 6'd0};

    rst = 1'b1;
    sd_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sd_out", sd_out, 1'b1);
    check_eq("rst_cmd_valid", cmd_valid, 1'b0);
    check_eq("rst_cmd_index", cmd_index, 6'd0);
    check_eq("rst_crc_err", crc_err, 1'b0);
    check_eq("rst_in_idle", in_idle, 1'b1);
    rst = 1'b0;

    // Directed: CMD0, CMD8, corrupted CMD0s, illegal commands, init, CMD58
    run_cmd(48'h40_0000_0000_95);
    run_cmd(48'h48_0000_01AA_87);
    run_cmd(48'h40_0000_0000_94);
    run_cmd(48'h40_0000_0000_97);
    run_cmd(make_frame(6'd41, 32'h0, 1'b0, 1'b0));
    run_cmd(make_frame(6'd13, 32'h0, 1'b0, 1'b0));
    init_seq();
    run_cmd(make_frame(6'd58, 32'h0, 1'b0, 1'b0));

    // Frame with transmission bit 0 must be dropped silently
    sd_in = 1'b0; @(posedge clk); #1;
    sd_in = 1'b0; @(posedge clk); #1;
    sd_in = 1'b1;
    saw_valid = 1'b0;
    saw_low = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (cmd_valid) saw_valid = 1'b1;
      if (!sd_out) saw_low = 1'b1;
    end
    check_eq("abort_no_valid", saw_valid, 1'b0);
    check_eq("abort_no_resp", saw_low, 1'b0);
    run_cmd(make_frame(6'd8, 32'h0000_0155, 1'b0, 1'b0));

    // Random command stream
    for (int n = 0; n < 80; n++) begin
      logic [5:0] idx;
      idx = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : pick[$urandom_range(0, 8)];
      run_cmd(make_frame(idx, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0)));
    end

    // Reset in the middle of an R7 after the card became ready
    run_cmd(48'h40_0000_0000_95);
    init_seq();
    f = make_frame(6'd8, 32'h0000_01AA, 1'b0, 1'b0);
    model_cmd(f, e_err, nbytes);
    drive_frame(f);
    repeat (NCR_P + 1 + 12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midtx_sd_out", sd_out, 1'b1);
    check_eq("midtx_in_idle", in_idle, 1'b1);
    check_eq("midtx_cmd_valid", cmd_valid, 1'b0);
    check_eq("midtx_cmd_index", cmd_index, 6'd0);
    check_eq("midtx_crc_err", crc_err, 1'b0);
    rst = 1'b0;
    model_reset();
    saw_low = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (!sd_out) saw_low = 1'b1;
    end
    check_eq("midtx_discard", saw_low, 1'b0);
    run_cmd(48'h40_0000_0000_95);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
